// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined float add/subtract: flush-to-zero, round-to-nearest-even, fp32 by default.
// Defining FP_ADDSUB_FLAGS_EN adds out_flags = {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_op,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FP_ADDSUB_FLAGS_EN
    output logic [3:0]           out_flags,
`endif
    output logic [EXP_W+MAN_W:0] out_z
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int X   = MAN_W + 4;             // hidden + mantissa + guard/round/sticky
    localparam int LZW = $clog2(X + 1);
    localparam int EW  = (EXP_W + 2 > LZW + 1) ? EXP_W + 2 : LZW + 1;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: unpack, swap, align ----------------
    logic [EXP_W-1:0] ea, eb, e_l, e_s, d;
    logic [MAN_W-1:0] ma_f, mb_f;
    logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
    logic [X-1:0]     sig_s_ext, s1_sig_l_d, s1_sig_s_d;
    logic             s1_nan_d, s1_inf_d, s1_inf_sign_d, s1_zsign_d, s1_sign_d, s1_sub_d;

    assign ea     = in_a[MAN_W +: EXP_W];
    assign eb     = in_b[MAN_W +: EXP_W];
    assign sa     = in_a[W-1];
    assign sb     = in_b[W-1] ^ in_op;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign ma_f   = a_zero ? '0 : in_a[MAN_W-1:0];
    assign mb_f   = b_zero ? '0 : in_b[MAN_W-1:0];
    assign a_inf  = (ea == EMAX) && (in_a[MAN_W-1:0] == '0);
    assign b_inf  = (eb == EMAX) && (in_b[MAN_W-1:0] == '0);
    assign a_nan  = (ea == EMAX) && (in_a[MAN_W-1:0] != '0);
    assign b_nan  = (eb == EMAX) && (in_b[MAN_W-1:0] != '0);

    always_comb begin
        swap          = {eb, mb_f} > {ea, ma_f};
        e_l           = swap ? eb : ea;
        e_s           = swap ? ea : eb;
        s1_sig_l_d    = swap ? {~b_zero, mb_f, 3'b000} : {~a_zero, ma_f, 3'b000};
        sig_s_ext     = swap ? {~a_zero, ma_f, 3'b000} : {~b_zero, mb_f, 3'b000};
        d             = e_l - e_s;
        if (32'(d) >= 32'(X - 1)) begin
            s1_sig_s_d = {{(X-1){1'b0}}, |sig_s_ext};
        end else begin
            s1_sig_s_d = (sig_s_ext >> d)
                       | {{(X-1){1'b0}}, |(sig_s_ext & ~({X{1'b1}} << d))};
        end
        s1_sign_d     = swap ? sb : sa;
        s1_sub_d      = sa ^ sb;
        s1_nan_d      = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
        s1_inf_d      = a_inf || b_inf;
        s1_inf_sign_d = a_inf ? sa : sb;
        s1_zsign_d    = a_zero && b_zero && sa && sb;
    end

    logic             s1_valid_q, s1_nan_q, s1_inf_q, s1_inf_sign_q, s1_zsign_q, s1_sign_q, s1_sub_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [X-1:0]     s1_sig_l_q, s1_sig_s_q;

    // ---------------- stage 2: magnitude add/subtract ----------------
    logic [X:0]       s2_sum_d, s2_sum_q;
    logic             s2_valid_q, s2_nan_q, s2_inf_q, s2_inf_sign_q, s2_zsign_q, s2_sign_q;
    logic [EXP_W-1:0] s2_exp_q;

    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_sig_l_q} - {1'b0, s1_sig_s_q})
                               : ({1'b0, s1_sig_l_q} + {1'b0, s1_sig_s_q});

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [LZW-1:0]     lz;
    logic [X-1:0]       norm;
    logic [EW-1:0]      e_n, e_f;
    logic [EW+MAN_W-1:0] pk;
    logic               carry, round_up, is_zero, uf, of;
    logic [W-1:0]       out_z_d;

    always_comb begin
        lz = LZW'(X);
        for (int i = 0; i < X; i++) begin
            if (s2_sum_q[i]) lz = LZW'(X - 1 - i);
        end
        carry = s2_sum_q[X];
        if (carry) begin
            norm = {s2_sum_q[X:2], |s2_sum_q[1:0]};
            e_n  = EW'(s2_exp_q) + EW'(1);
        end else begin
            norm = s2_sum_q[X-1:0] << lz;
            e_n  = EW'(s2_exp_q) - EW'(lz);
        end
        round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
        // Packing exponent above the mantissa lets a rounding carry bump the exponent.
        pk       = {e_n, norm[X-2:3]} + (EW+MAN_W)'(round_up);
        e_f      = pk[EW+MAN_W-1:MAN_W];
        is_zero  = !norm[X-1];
        uf       = !is_zero && (e_f[EW-1] || (e_f == '0));
        of       = !is_zero && !uf && (e_f >= EW'(EMAX));

        if (s2_nan_q)      out_z_d = QNAN;
        else if (s2_inf_q) out_z_d = {s2_inf_sign_q, EMAX, {MAN_W{1'b0}}};
        else if (is_zero)  out_z_d = {s2_zsign_q, {(W-1){1'b0}}};
        else if (uf)       out_z_d = {s2_sign_q, {(W-1){1'b0}}};
        else if (of)       out_z_d = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
        else               out_z_d = {s2_sign_q, e_f[EXP_W-1:0], pk[MAN_W-1:0]};
    end

    logic         out_valid_q;
    logic [W-1:0] out_z_q;

`ifdef FP_ADDSUB_FLAGS_EN
    logic       s1_inv_d, s1_inv_q, s2_inv_q, fin;
    logic [3:0] flags_d, flags_q;
    assign s1_inv_d = (a_inf && b_inf && (sa != sb))
                   || (a_nan && !in_a[MAN_W-1]) || (b_nan && !in_b[MAN_W-1]);
    assign fin      = !s2_nan_q && !s2_inf_q;
    assign flags_d  = {s2_inv_q, fin && of, fin && uf,
                       fin && !is_zero && ((|norm[2:0]) || of || uf)};
    assign out_flags = flags_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
            flags_q     <= '0;
`endif
        end else if (adv) begin
            s1_valid_q    <= in_valid;
            s1_nan_q      <= s1_nan_d;
            s1_inf_q      <= s1_inf_d;
            s1_inf_sign_q <= s1_inf_sign_d;
            s1_zsign_q    <= s1_zsign_d;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= s1_sub_d;
            s1_exp_q      <= e_l;
            s1_sig_l_q    <= s1_sig_l_d;
            s1_sig_s_q    <= s1_sig_s_d;

            s2_valid_q    <= s1_valid_q;
            s2_nan_q      <= s1_nan_q;
            s2_inf_q      <= s1_inf_q;
            s2_inf_sign_q <= s1_inf_sign_q;
            s2_zsign_q    <= s1_zsign_q;
            s2_sign_q     <= s1_sign_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= s2_sum_d;

            out_valid_q   <= s2_valid_q;
            out_z_q       <= out_z_d;
`ifdef FP_ADDSUB_FLAGS_EN
            s1_inv_q      <= s1_inv_d;
            s2_inv_q      <= s1_inv_q;
            flags_q       <= flags_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
endmodule
